// File: rtl/spram_multibank_controller.sv
// Weight-store controller: 1, 2 or 4 SPRAM banks (16K x 16 each) as one linear space.
// Single-beat host port (priority) plus a burst-read port for the systolic array,
// with a starvation guard that forces the array a slot after STARVE_LIMIT losses.
module spram_multibank_controller #(
  parameter int unsigned NUM_BANKS    = 4,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned LEN_WIDTH    = 6,
  parameter int unsigned STARVE_LIMIT = 8,
  localparam int unsigned BANK_BITS   = $clog2(NUM_BANKS),
  localparam int unsigned ADDR_WIDTH  = 14 + BANK_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  host_req_valid,
  output logic                  host_req_ready,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic [1:0]            host_wmask,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  input  logic                  array_req_valid,
  output logic                  array_req_ready,
  input  logic [ADDR_WIDTH-1:0] array_addr,
  input  logic [LEN_WIDTH-1:0]  array_len,
  output logic                  array_rvalid,
  output logic [DATA_WIDTH-1:0] array_rdata,
  output logic                  array_rlast,
  output logic                  array_busy
);

  localparam int unsigned BankW = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int unsigned Rows  = 16384;

  typedef enum logic [0:0] {AIdle, ABurst} astate_e;

  astate_e               astate_q, astate_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
  logic [7:0]            starve_cnt_q, starve_cnt_d;

  logic                  force_array, host_take, beat_issue, beat_last;
  logic                  acc_en, acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [BankW-1:0]      acc_bank;
  logic [13:0]           acc_row;
  logic [3:0]            acc_maskwren;
  logic [NUM_BANKS-1:0]  bank_cs;
  logic [DATA_WIDTH-1:0] bank_dout [NUM_BANKS];

  logic                  t1_valid_q, t1_owner_q, t1_last_q;
  logic [BankW-1:0]      t1_bank_q;
  logic                  host_rvalid_q, array_rvalid_q, array_rlast_q;
  logic [DATA_WIDTH-1:0] host_rdata_q, array_rdata_q;

  // Host wins every slot unless the array has lost STARVE_LIMIT in a row.
  assign force_array    = (astate_q == ABurst) && (starve_cnt_q == 8'(STARVE_LIMIT));
  assign host_req_ready = rst_n & ~force_array;
  assign host_take      = host_req_valid & rst_n & ~force_array;

  // Burst state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      astate_q     <= AIdle;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      starve_cnt_q <= '0;
    end else begin
      astate_q     <= astate_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Burst next-state: latch descriptor, step address/count per beat, track losses.
  always_comb begin
    astate_d     = astate_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    starve_cnt_d = starve_cnt_q;
    case (astate_q)
      AIdle: begin
        starve_cnt_d = '0;
        if (array_req_valid) begin
          cur_addr_d   = array_addr;
          beats_left_d = array_len;
          astate_d     = ABurst;
        end
      end
      ABurst: begin
        if (beat_issue) begin
          // Address wraps modulo the full space, so bursts cross banks freely.
          cur_addr_d   = cur_addr_q + ADDR_WIDTH'(1);
          beats_left_d = beats_left_q - LEN_WIDTH'(1);
          starve_cnt_d = '0;
          if (beat_last) astate_d = AIdle;
        end else if (host_take) begin
          starve_cnt_d = starve_cnt_q + 8'd1;
        end
      end
      default: astate_d = AIdle;
    endcase
  end

  // Burst outputs: descriptor ready in idle, beat issue when the host leaves the slot.
  always_comb begin
    array_req_ready = 1'b0;
    beat_issue      = 1'b0;
    beat_last       = 1'b0;
    case (astate_q)
      AIdle:   array_req_ready = rst_n;
      ABurst: begin
        beat_issue = ~host_take;
        beat_last  = (beats_left_q == '0);
      end
      default: ;
    endcase
  end

  // Single SPRAM access per cycle: host if it takes the slot, else the array beat.
  always_comb begin
    acc_en       = host_take | beat_issue;
    acc_we       = host_take & host_we;
    acc_addr     = host_take ? host_addr : cur_addr_q;
    acc_maskwren = {host_wmask[1], host_wmask[1], host_wmask[0], host_wmask[0]};
  end

  assign acc_row = acc_addr[13:0];

  if (BANK_BITS == 0) begin : g_one_bank
    assign acc_bank = '0;
  end else begin : g_multi_bank
    assign acc_bank = acc_addr[ADDR_WIDTH-1 -: BankW];
  end

  // Chip-select decode: only the addressed bank is enabled.
  always_comb begin
    bank_cs = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_cs[b] = acc_en & (acc_bank == BankW'(b));
    end
  end

  // Behavioural SB_SPRAM256KA (STANDBY=0, SLEEP=0, POWEROFF=1): registered read,
  // nibble write enables, DATAOUT held across writes. Contents are never reset.
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [Rows];
    logic [DATA_WIDTH-1:0] dout;

    // Bank array access.
    always_ff @(posedge clk) begin
      if (bank_cs[g]) begin
        if (acc_we) begin
          for (int n = 0; n < 4; n++) begin
            if (acc_maskwren[n]) mem[acc_row][n*4 +: 4] <= host_wdata[n*4 +: 4];
          end
        end else begin
          dout <= mem[acc_row];
        end
      end
    end

    assign bank_dout[g] = dout;
  end

  // Tag stage: remembers owner/bank/last of the read the banks are serving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t1_valid_q <= 1'b0;
      t1_owner_q <= 1'b0;
      t1_last_q  <= 1'b0;
      t1_bank_q  <= '0;
    end else begin
      t1_valid_q <= (host_take & ~host_we) | beat_issue;
      t1_owner_q <= beat_issue;
      t1_last_q  <= beat_issue & beat_last;
      t1_bank_q  <= acc_bank;
    end
  end

  // Output stage: steer the tagged bank's DATAOUT to its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rvalid_q  <= 1'b0;
      array_rvalid_q <= 1'b0;
      array_rlast_q  <= 1'b0;
      host_rdata_q   <= '0;
      array_rdata_q  <= '0;
    end else begin
      host_rvalid_q  <= t1_valid_q & ~t1_owner_q;
      array_rvalid_q <= t1_valid_q & t1_owner_q;
      array_rlast_q  <= t1_valid_q & t1_owner_q & t1_last_q;
      if (t1_valid_q & ~t1_owner_q) host_rdata_q  <= bank_dout[t1_bank_q];
      if (t1_valid_q &  t1_owner_q) array_rdata_q <= bank_dout[t1_bank_q];
    end
  end

  assign host_rvalid  = host_rvalid_q;
  assign host_rdata   = host_rdata_q;
  assign array_rvalid = array_rvalid_q;
  assign array_rdata  = array_rdata_q;
  assign array_rlast  = array_rlast_q;
  // Busy spans descriptor acceptance through the last beat's rvalid cycle.
  assign array_busy   = (astate_q == ABurst) | (t1_valid_q & t1_owner_q) | array_rvalid_q;

endmodule

// File: tb/tb_spram_multibank_controller.sv
// Self-checking bench for spram_multibank_controller (4 banks, STARVE_LIMIT=2).
module tb_spram_multibank_controller;
  localparam int unsigned NB = 4;
  localparam int unsigned LW = 6;
  localparam int unsigned SL = 2;
  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          host_req_valid, host_req_ready, host_we;
  logic [AW-1:0] host_addr;
  logic [15:0]   host_wdata;
  logic [1:0]    host_wmask;
  logic          host_rvalid;
  logic [15:0]   host_rdata;
  logic          array_req_valid, array_req_ready;
  logic [AW-1:0] array_addr;
  logic [LW-1:0] array_len;
  logic          array_rvalid;
  logic [15:0]   array_rdata;
  logic          array_rlast, array_busy;

  logic [15:0] ref_mem [65536];
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  spram_multibank_controller #(
    .NUM_BANKS(NB), .DATA_WIDTH(16), .LEN_WIDTH(LW), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_wmask(host_wmask),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .array_req_valid(array_req_valid), .array_req_ready(array_req_ready),
    .array_addr(array_addr), .array_len(array_len),
    .array_rvalid(array_rvalid), .array_rdata(array_rdata),
    .array_rlast(array_rlast), .array_busy(array_busy)
  );

  // Byte-lane write rule: bit1 covers [15:8], bit0 covers [7:0].
  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] m);
    merge = old;
    if (m[1]) merge[15:8] = d[15:8];
    if (m[0]) merge[7:0] = d[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    host_req_valid = 0; host_we = 0; host_addr = '0; host_wdata = '0; host_wmask = '0;
    array_req_valid = 0; array_addr = '0; array_len = '0;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] m);
    host_req_valid = 1; host_we = 1; host_addr = a; host_wdata = d; host_wmask = m;
    n_checks++;
    if (host_req_ready !== 1'b1)
      $display("FAIL host_write_ready @%h: got %b want 1", a, host_req_ready);
    else n_pass++;
    tick();
    host_req_valid = 0; host_we = 0;
    ref_mem[a] = merge(ref_mem[a], d, m);
  endtask

  task automatic host_read_check(input logic [AW-1:0] a, input logic [15:0] exp_d,
                                 input string tag);
    host_req_valid = 1; host_we = 0; host_addr = a;
    tick();
    host_req_valid = 0;
    n_checks++;
    if (host_rvalid !== 1'b0) $display("FAIL %s_early @%h: rvalid=%b want 0", tag, a, host_rvalid);
    else n_pass++;
    tick();
    n_checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== exp_d)
      $display("FAIL %s @%h: rvalid=%b data=%h want rvalid=1 data=%h",
               tag, a, host_rvalid, host_rdata, exp_d);
    else n_pass++;
    tick();
    n_checks++;
    if (host_rvalid !== 1'b0) $display("FAIL %s_pulse @%h: rvalid=%b want 0", tag, a, host_rvalid);
    else n_pass++;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({host_req_ready, array_req_ready, host_rvalid, array_rvalid, array_rlast, array_busy,
         host_rdata, array_rdata} !== '0)
      $display("FAIL reset_outputs: hrdy=%b ardy=%b hrv=%b arv=%b last=%b busy=%b want all 0",
               host_req_ready, array_req_ready, host_rvalid, array_rvalid, array_rlast, array_busy);
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
    #1;
    n_checks++;
    if ({host_req_ready, array_req_ready, array_busy} !== 3'b110)
      $display("FAIL reset_release: hrdy=%b ardy=%b busy=%b want 1 1 0",
               host_req_ready, array_req_ready, array_busy);
    else n_pass++;
  endtask

  task automatic test_write_read();
    host_req_valid = 1; host_we = 1; host_addr = 16'h0000; host_wdata = 16'hA5A5;
    host_wmask = 2'b11;
    #1;
    n_checks++;
    if (dut.bank_cs !== 4'b0001) $display("FAIL cs_bank0: got %b want 0001", dut.bank_cs);
    else n_pass++;
    tick();
    ref_mem[16'h0000] = 16'hA5A5;
    host_addr = 16'hC001; host_wdata = 16'h1234;
    #1;
    n_checks++;
    if (dut.bank_cs !== 4'b1000) $display("FAIL cs_bank3: got %b want 1000", dut.bank_cs);
    else n_pass++;
    tick();
    ref_mem[16'hC001] = 16'h1234;
    host_req_valid = 0; host_we = 0;
    tick();
    n_checks++;
    if (host_rvalid !== 1'b0) $display("FAIL write_no_rvalid: got %b want 0", host_rvalid);
    else n_pass++;
    host_read_check(16'h0000, 16'hA5A5, "read_0000");
    host_read_check(16'hC001, 16'h1234, "read_C001");
  endtask

  task automatic test_byte_mask();
    host_write(16'd5, 16'hFFFF, 2'b11);
    host_write(16'd5, 16'h0000, 2'b01);
    host_read_check(16'd5, 16'hFF00, "mask_low");
    host_write(16'd5, 16'($urandom), 2'b00);
    host_read_check(16'd5, 16'hFF00, "mask_none");
  endtask

  task automatic test_random_host();
    logic [AW-1:0] pool [8];
    bit            is_rd [40];
    logic [15:0]   exp_d [40];
    int            k;
    for (int i = 0; i < 8; i++) pool[i] = AW'($urandom);
    for (int i = 0; i < 8; i++) host_write(pool[i], 16'($urandom), 2'b11);
    for (int i = 0; i <= 40; i++) begin
      if (i < 40) begin
        k = $urandom_range(0, 7);
        host_req_valid = 1; host_we = 1'($urandom_range(0, 1)); host_addr = pool[k];
        host_wdata = 16'($urandom); host_wmask = 2'($urandom);
        is_rd[i] = !host_we;
        if (host_we) ref_mem[host_addr] = merge(ref_mem[host_addr], host_wdata, host_wmask);
        else exp_d[i] = ref_mem[host_addr];
      end else begin
        host_req_valid = 0; host_we = 0;
      end
      tick();
      if (i >= 1) begin
        n_checks++;
        if (host_rvalid !== is_rd[i-1] || (is_rd[i-1] && host_rdata !== exp_d[i-1]))
          $display("FAIL rand_host op%0d: rvalid=%b data=%h want rvalid=%b data=%h",
                   i - 1, host_rvalid, host_rdata, is_rd[i-1], exp_d[i-1]);
        else n_pass++;
      end
    end
  endtask

  // Issues one burst; optionally holds host reads of ha valid for the whole burst.
  task automatic run_burst(input logic [AW-1:0] a, input int len, input bit hold,
                           input logic [AW-1:0] ha, input string tag);
    int            exp_last, exp_cyc;
    int            got_cyc [$];
    logic [15:0]   got_dat [$];
    logic          got_last [$];
    logic          exp_rdy;
    logic [AW-1:0] ba;
    // Beat j is issued in slot j (idle host) or slot j*(SL+1)+SL (host always asking),
    // and becomes visible two samples later.
    exp_last = (hold ? len * (SL + 1) + SL : len) + 2;
    array_req_valid = 1; array_addr = a; array_len = LW'(len);
    host_req_valid = hold; host_we = 0; host_addr = ha;
    n_checks++;
    if (array_req_ready !== 1'b1) $display("FAIL %s_desc_ready: got %b want 1", tag, array_req_ready);
    else n_pass++;
    tick();
    array_req_valid = 0;
    for (int cyc = 0; cyc <= exp_last + 1; cyc++) begin
      if (hold) begin
        exp_rdy = !((cyc < (len + 1) * (SL + 1)) && (cyc % (SL + 1) == SL));
        n_checks++;
        if (host_req_ready !== exp_rdy)
          $display("FAIL %s_host_ready slot%0d: got %b want %b", tag, cyc, host_req_ready, exp_rdy);
        else n_pass++;
      end
      n_checks++;
      if (array_busy !== (cyc <= exp_last))
        $display("FAIL %s_busy cyc%0d: got %b want %b", tag, cyc, array_busy, cyc <= exp_last);
      else n_pass++;
      if (cyc == 0 || cyc == exp_last + 1) begin
        n_checks++;
        if (array_req_ready !== (cyc != 0))
          $display("FAIL %s_array_ready cyc%0d: got %b want %b", tag, cyc, array_req_ready, cyc != 0);
        else n_pass++;
      end
      if (array_rvalid === 1'b1) begin
        got_cyc.push_back(cyc); got_dat.push_back(array_rdata); got_last.push_back(array_rlast);
      end
      if (host_rvalid === 1'b1) begin
        n_checks++;
        if (host_rdata !== ref_mem[ha])
          $display("FAIL %s_host_data: got %h want %h", tag, host_rdata, ref_mem[ha]);
        else n_pass++;
      end
      if (cyc == exp_last + 1) host_req_valid = 0;
      tick();
    end
    repeat (2) begin
      if (array_rvalid === 1'b1) begin
        got_cyc.push_back(-1); got_dat.push_back(array_rdata); got_last.push_back(array_rlast);
      end
      if (host_rvalid === 1'b1) begin
        n_checks++;
        if (host_rdata !== ref_mem[ha])
          $display("FAIL %s_host_data_tail: got %h want %h", tag, host_rdata, ref_mem[ha]);
        else n_pass++;
      end
      tick();
    end
    n_checks++;
    if (got_cyc.size() != len + 1)
      $display("FAIL %s_beat_count: got %0d want %0d", tag, got_cyc.size(), len + 1);
    else n_pass++;
    for (int j = 0; j < got_cyc.size() && j <= len; j++) begin
      ba = a + AW'(j);
      exp_cyc = (hold ? j * (SL + 1) + SL : j) + 2;
      n_checks++;
      if (got_dat[j] !== ref_mem[ba] || got_last[j] !== (j == len) || got_cyc[j] != exp_cyc)
        $display("FAIL %s_beat%0d: data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d",
                 tag, j, got_dat[j], got_last[j], got_cyc[j], ref_mem[ba], j == len, exp_cyc);
      else n_pass++;
    end
  endtask

  task automatic test_bank_cross();
    for (int j = 0; j < 4; j++) host_write(16'h3FFE + AW'(j), 16'(j + 1), 2'b11);
    run_burst(16'h3FFE, 3, 1'b0, 16'h0000, "xbank");
  endtask

  task automatic test_starvation();
    run_burst(16'h3FFE, 3, 1'b1, 16'hC001, "starve");
  endtask

  task automatic test_wrap();
    host_write(16'hFFFF, 16'($urandom), 2'b11);
    host_write(16'h0000, 16'($urandom), 2'b11);
    run_burst(16'hFFFF, 1, 1'b0, 16'h0000, "wrap");
  endtask

  task automatic test_random_bursts();
    logic [AW-1:0] a;
    int            len;
    bit            hold;
    for (int t = 0; t < 6; t++) begin
      a = AW'($urandom);
      len = $urandom_range(0, 12);
      hold = 1'($urandom_range(0, 1));
      for (int j = 0; j <= len; j++) host_write(a + AW'(j), 16'($urandom), 2'b11);
      run_burst(a, len, hold, a, "rburst");
    end
  endtask

  task automatic test_reset_midburst();
    logic [AW-1:0] a;
    int            stray;
    a = 16'h8123;
    for (int j = 0; j < 8; j++) host_write(a + AW'(j), 16'($urandom), 2'b11);
    array_req_valid = 1; array_addr = a; array_len = LW'(7);
    tick();
    array_req_valid = 0;
    repeat (3) tick();
    n_checks++;
    if (array_rvalid !== 1'b1 || array_rdata !== ref_mem[a + AW'(1)])
      $display("FAIL midburst_beat2: rvalid=%b data=%h want 1 %h",
               array_rvalid, array_rdata, ref_mem[a + AW'(1)]);
    else n_pass++;
    rst_n = 0;
    #1;
    n_checks++;
    if ({host_req_ready, array_req_ready, host_rvalid, array_rvalid, array_rlast, array_busy,
         host_rdata, array_rdata} !== '0)
      $display("FAIL midburst_reset_outputs: hrdy=%b ardy=%b arv=%b busy=%b data=%h want all 0",
               host_req_ready, array_req_ready, array_rvalid, array_busy, array_rdata);
    else n_pass++;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    n_checks++;
    if ({host_req_ready, array_req_ready, array_busy} !== 3'b110)
      $display("FAIL midburst_release: hrdy=%b ardy=%b busy=%b want 1 1 0",
               host_req_ready, array_req_ready, array_busy);
    else n_pass++;
    stray = 0;
    repeat (12) begin
      tick();
      if (host_rvalid !== 1'b0 || array_rvalid !== 1'b0 || array_busy !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0) $display("FAIL midburst_stray: got %0d stray cycles want 0", stray);
    else n_pass++;
    for (int j = 0; j < 8; j++) host_read_check(a + AW'(j), ref_mem[a + AW'(j)], "post_reset");
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_byte_mask();
    test_random_host();
    test_bank_cross();
    test_starvation();
    test_wrap();
    test_random_bursts();
    test_reset_midburst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
